// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with handshaked, glitch-free reconfiguration,
// burst / continuous modes and graceful stop that never truncates a high phase.
module clkdiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [21:0] cfg_maxcount,
    input  logic [7:0]  cfg_pulses,
    input  logic        start,
    input  logic        stop,
    output logic        sclk,
    output logic        sclk_rise,
    output logic        busy,
    output logic        done,
    output logic [21:0] cur_maxcount
);

    localparam int unsigned CW = 22;
    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [CW-1:0]   cur_nxt;
    logic [PW-1:0]   pulses, pulses_nxt;
    logic [PW-1:0]   remaining, remaining_nxt;
    logic            burst, burst_nxt;
    logic            shadow_valid, shadow_valid_nxt;
    logic [CW-1:0]   shadow_maxcount, shadow_maxcount_nxt;
    logic [PW-1:0]   shadow_pulses, shadow_pulses_nxt;
    logic            sclk_nxt, rise_nxt, done_nxt, busy_nxt, ready_nxt;

    logic            accept;
    logic            toggle;
    logic            go_idle;
    logic [CW-1:0]   cfg_mc_eff;
    logic [PW-1:0]   start_pulses;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            sclk            <= 1'b0;
            sclk_rise       <= 1'b0;
            done            <= 1'b0;
            busy            <= 1'b0;
            cfg_ready       <= 1'b1;
            cur_maxcount    <= CW'(1);
            pulses          <= '0;
            remaining       <= '0;
            burst           <= 1'b0;
            shadow_valid    <= 1'b0;
            shadow_maxcount <= CW'(1);
            shadow_pulses   <= '0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            sclk            <= sclk_nxt;
            sclk_rise       <= rise_nxt;
            done            <= done_nxt;
            busy            <= busy_nxt;
            cfg_ready       <= ready_nxt;
            cur_maxcount    <= cur_nxt;
            pulses          <= pulses_nxt;
            remaining       <= remaining_nxt;
            burst           <= burst_nxt;
            shadow_valid    <= shadow_valid_nxt;
            shadow_maxcount <= shadow_maxcount_nxt;
            shadow_pulses   <= shadow_pulses_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt           = state;
        count_nxt           = count;
        sclk_nxt            = sclk;
        rise_nxt            = 1'b0;
        done_nxt            = 1'b0;
        cur_nxt             = cur_maxcount;
        pulses_nxt          = pulses;
        remaining_nxt       = remaining;
        burst_nxt           = burst;
        shadow_valid_nxt    = shadow_valid;
        shadow_maxcount_nxt = shadow_maxcount;
        shadow_pulses_nxt   = shadow_pulses;
        go_idle             = 1'b0;

        accept       = cfg_valid && cfg_ready;
        cfg_mc_eff   = (cfg_maxcount == '0) ? CW'(1) : cfg_maxcount;
        toggle       = (count == cur_maxcount - CW'(1));
        start_pulses = accept ? cfg_pulses : pulses;

        case (state)
            IDLE: begin
                if (accept) begin
                    cur_nxt    = cfg_mc_eff;
                    pulses_nxt = cfg_pulses;
                end
                if (start && !stop) begin
                    state_nxt     = RUN;
                    count_nxt     = '0;
                    sclk_nxt      = 1'b0;
                    remaining_nxt = start_pulses;
                    burst_nxt     = (start_pulses != '0);
                end
            end
            RUN: begin
                if (accept) begin
                    shadow_valid_nxt    = 1'b1;
                    shadow_maxcount_nxt = cfg_mc_eff;
                    shadow_pulses_nxt   = cfg_pulses;
                end
                if (stop && !sclk) begin
                    go_idle = 1'b1;
                end else if (toggle) begin
                    // A fall that ends the burst or honours a stop returns to IDLE
                    if (sclk && (stop || (burst && remaining == PW'(1)))) begin
                        go_idle = 1'b1;
                    end else begin
                        sclk_nxt  = !sclk;
                        rise_nxt  = !sclk;
                        count_nxt = '0;
                        if (sclk && burst) begin
                            remaining_nxt = remaining - PW'(1);
                        end
                        if (shadow_valid) begin
                            cur_nxt          = shadow_maxcount;
                            pulses_nxt       = shadow_pulses;
                            shadow_valid_nxt = 1'b0;
                        end
                    end
                end else begin
                    count_nxt = count + CW'(1);
                    if (stop) begin
                        state_nxt = STOPPING;
                    end
                end
            end
            STOPPING: begin
                if (toggle) begin
                    go_idle = 1'b1;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (go_idle) begin
            state_nxt        = IDLE;
            count_nxt        = '0;
            sclk_nxt         = 1'b0;
            done_nxt         = 1'b1;
            shadow_valid_nxt = 1'b0;
        end

        busy_nxt  = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE) || ((state_nxt == RUN) && !shadow_valid_nxt);
    end

endmodule
